// File: rtl/datapath_pkg.sv
// Shared constants, line record and address helpers for the read-only cache.
package datapath_pkg;

  localparam int DEF_ADDR_W   = 15;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_INDEX_W  = 6;
  localparam int DEF_OFFSET_W = 2;
  localparam int TAG_W        = DEF_ADDR_W - DEF_INDEX_W - DEF_OFFSET_W;
  localparam int WORDS        = 1 << DEF_OFFSET_W;
  localparam int BLK_W        = DEF_ADDR_W - DEF_OFFSET_W;

  typedef logic [DEF_ADDR_W-1:0]               addr_t;
  typedef logic [DEF_DATA_W-1:0]               word_t;
  typedef logic [WORDS-1:0][DEF_DATA_W-1:0]    block_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    block_t           data;
  } line_t;

  function automatic logic [TAG_W-1:0] get_tag(input addr_t a);
    return a[DEF_ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [DEF_INDEX_W-1:0] get_index(input addr_t a);
    return a[DEF_OFFSET_W +: DEF_INDEX_W];
  endfunction

  function automatic logic [DEF_OFFSET_W-1:0] get_offset(input addr_t a);
    return a[DEF_OFFSET_W-1:0];
  endfunction

  function automatic logic [BLK_W-1:0] get_block(input addr_t a);
    return a[DEF_ADDR_W-1:DEF_OFFSET_W];
  endfunction

  // Fixed backing-store pattern: the address replicated in each half-word.
  function automatic word_t mem_word(input addr_t a);
    return {1'b0, a, 1'b0, a};
  endfunction

endpackage

// File: rtl/datapath_main_mem.sv
// Main-memory model: fixed content derived from the address.
// MISS_FORWARD_EN adds a single-word read port used to forward data on a miss.
module main_mem
  import datapath_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int OFFSET_W = DEF_OFFSET_W
) (
  input  logic [ADDR_W-OFFSET_W-1:0]                blk_addr,
  output logic [(1<<OFFSET_W)-1:0][DATA_W-1:0]      blk_data
`ifdef MISS_FORWARD_EN
  ,
  input  logic [ADDR_W-1:0]                         word_addr,
  output logic [DATA_W-1:0]                         word_data
`endif
);

  localparam int NW = 1 << OFFSET_W;

  // Block read port: all words of the addressed block at once.
  always_comb begin
    blk_data = '0;
    for (int w = 0; w < NW; w++) begin
      blk_data[w] = mem_word({blk_addr, OFFSET_W'(w)});
    end
  end

`ifdef MISS_FORWARD_EN
  // Single-word read port.
  always_comb begin
    word_data = mem_word(word_addr);
  end
`endif

endmodule

// File: rtl/datapath.sv
// Direct-mapped read-only cache in front of a fixed main-memory model.
// A miss fills the whole block on the next rising edge (one-cycle miss-to-hit).
// Optional macro MISS_FORWARD_EN: forward the main-memory word on a miss
// instead of returning zero.
module datapath
  import datapath_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int INDEX_W  = DEF_INDEX_W,
  parameter int OFFSET_W = DEF_OFFSET_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  output logic              hit,
  output logic [DATA_W-1:0] outData
);

  localparam int LINES = 1 << INDEX_W;

  line_t                lines [LINES];
  line_t                cur_line;
  logic [TAG_W-1:0]     cur_tag;
  logic [INDEX_W-1:0]   cur_index;
  logic [OFFSET_W-1:0]  cur_offset;
  block_t               fill_data;
  logic [DATA_W-1:0]    miss_data;

  assign cur_tag    = get_tag(address);
  assign cur_index  = get_index(address);
  assign cur_offset = get_offset(address);
  assign cur_line   = lines[cur_index];

`ifdef MISS_FORWARD_EN
  main_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OFFSET_W(OFFSET_W)) u_main_mem (
    .blk_addr  (get_block(address)),
    .blk_data  (fill_data),
    .word_addr (address),
    .word_data (miss_data)
  );
`else
  main_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OFFSET_W(OFFSET_W)) u_main_mem (
    .blk_addr  (get_block(address)),
    .blk_data  (fill_data)
  );
  assign miss_data = '0;
`endif

  // Hit detect and read mux; valid bits are cleared asynchronously so reset
  // forces a miss without touching tags or data.
  always_comb begin
    hit     = cur_line.valid && (cur_line.tag == cur_tag);
    outData = miss_data;
    if (hit) begin
      outData = cur_line.data[cur_offset];
    end
  end

  // Line storage: async clear of valid bits only; on a miss the whole line is
  // overwritten unconditionally (no write-back, read-only cache).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LINES; i++) begin
        lines[i].valid <= 1'b0;
      end
    end else if (!hit) begin
      lines[cur_index].valid <= 1'b1;
      lines[cur_index].tag   <= cur_tag;
      lines[cur_index].data  <= fill_data;
    end
  end

endmodule

// File: tb/tb_datapath.sv
// Directed bench for the read-only cache; inputs change on the falling edge,
// outputs are checked 1 ns later.
module tb_datapath;

  logic        clk;
  logic        rst;
  logic [14:0] address;
  logic        hit;
  logic [31:0] outData;

  int n_cmp = 0;
  int n_err = 0;

  datapath dut (
    .clk     (clk),
    .rst     (rst),
    .address (address),
    .hit     (hit),
    .outData (outData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", name, got, exp);
    end
  endtask

  // Expected outData on a miss depends on the build.
  function automatic logic [31:0] miss_val(input logic [14:0] a);
`ifdef MISS_FORWARD_EN
    return {1'b0, a, 1'b0, a};
`else
    return 32'h0 & {17'h0, a};
`endif
  endfunction

  task automatic expect_miss(input string name, input logic [14:0] a);
    chk({name, "_hit"}, {31'h0, hit}, 32'h0);
    chk({name, "_data"}, outData, miss_val(a));
  endtask

  task automatic expect_hit(input string name, input logic [31:0] d);
    chk({name, "_hit"}, {31'h0, hit}, 32'h1);
    chk({name, "_data"}, outData, d);
  endtask

  initial begin
    rst = 1'b1;
    address = 15'h0000;
    #1 rst = 1'b0;
    #1;
    chk("rst0_hit", {31'h0, hit}, 32'h0);
    chk("rst0_data", outData, 32'h0);
    @(negedge clk); #1;
    chk("rst1_hit", {31'h0, hit}, 32'h0);
    chk("rst1_data", outData, 32'h0);
    @(negedge clk); #1;
    chk("rst2_hit", {31'h0, hit}, 32'h0);
    chk("rst2_data", outData, 32'h0);

    // Cold miss then hit
    rst = 1'b1;
    address = 15'h0001;
    #1 expect_miss("cold_miss", 15'h0001);
    @(negedge clk); #1;
    expect_hit("cold_hit", 32'h00010001);

    // Same block
    address = 15'h0003;
    #1 expect_hit("same_blk", 32'h00030003);

    // Conflict eviction on line 0
    @(negedge clk);
    address = 15'h0800;
    #1 expect_miss("conf_miss", 15'h0800);
    @(negedge clk); #1;
    expect_hit("conf_hit", 32'h08000800);
    address = 15'h0001;
    #1 expect_miss("evict_miss", 15'h0001);
    @(negedge clk); #1;
    expect_hit("refill_hit", 32'h00010001);

    // Independent index 0x0D
    address = 15'h1234;
    #1 expect_miss("idx_miss", 15'h1234);
    @(negedge clk); #1;
    expect_hit("idx_hit", 32'h12341234);
    @(negedge clk); #1;
    expect_hit("idx_hold", 32'h12341234);
    address = 15'h0002;
    #1 expect_hit("line0_kept", 32'h00020002);

    // Fill uses the address present at the edge
    @(negedge clk);
    address = 15'h0400;
    #1 expect_miss("samp_first", 15'h0400);
    #2 address = 15'h0C00;
    @(negedge clk); #1;
    expect_hit("samp_edge", 32'h0C000C00);
    address = 15'h0400;
    #1 expect_miss("samp_other", 15'h0400);

    // Async reset while hitting
    @(negedge clk);
    address = 15'h1235;
    #1 expect_hit("pre_rst", 32'h12351235);
    #1 rst = 1'b0;
    #1 expect_miss("async_rst", 15'h1235);
    @(negedge clk); #1;
    expect_miss("rst_nofill", 15'h1235);
    rst = 1'b1;
    #1 expect_miss("post_rst", 15'h1235);
    @(negedge clk); #1;
    expect_hit("post_rst_hit", 32'h12351235);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 Parameter ADDR_W, default 15, word-address width.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter INDEX_W, default 6, cache line index width (64 lines).
REQ-004 Parameter OFFSET_W, default 2, word-in-block offset width (4 words/block); tag width = ADDR_W-INDEX_W-OFFSET_W (7).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 address  input  ADDR_W  word address of the current read request, presented every cycle.
REQ-008 hit  output  1  current address hits in the cache.
REQ-009 outData  output  DATA_W  read data for the current address.

Function
REQ-010 The block SHALL be a direct-mapped, read-only cache in front of an internal main-memory model; there is no write path.
REQ-011 Address split: tag = address[14:8], index = address[7:2], offset = address[1:0].
REQ-012 Each line SHALL hold a valid bit, a 7-bit tag and 4 data words.
REQ-013 hit SHALL be combinational: valid[index] AND stored_tag[index] == tag.
REQ-014 On hit, outData SHALL equal data[index][offset], combinationally, in the same cycle.
REQ-015 On miss, outData SHALL be 0 (see REQ-024 for the alternative).
REQ-016 Main-memory content SHALL be fixed: word(A) = {1'b0, A[14:0], 1'b0, A[14:0]}; for example, word(0x0001) = 0x00010001.
REQ-017 On a rising edge with rst high and hit low, the whole block (4 words at addresses {tag,index,0..3}) SHALL be loaded in one cycle, the tag written and valid set.
REQ-018 On a rising edge with hit high, no cache state SHALL change.
REQ-019 Miss-to-hit latency SHALL be exactly one clock: an address held constant misses for one cycle and then hits.
REQ-020 A conflicting miss SHALL overwrite the line unconditionally; there is no write-back.
REQ-021 The fill SHALL use the address value sampled at the rising edge; address changes between edges SHALL only affect combinational hit and outData.

Reset
REQ-022 rst low SHALL asynchronously clear all valid bits, forcing hit = 0 and outData = 0 while asserted; tag and data arrays are not reset.
REQ-023 No fill SHALL occur on any edge while rst is low; the first fill is allowed on the first rising edge after rst rises.

Configuration
REQ-024 Macro MISS_FORWARD_EN: when defined, outData on a miss SHALL equal main-memory word(address), combinationally; when undefined, outData on a miss SHALL be 0. hit behaviour and latency are identical in both builds.

Structure
REQ-025 Shared package datapath_pkg SHALL hold ADDR_W/DATA_W/INDEX_W/OFFSET_W defaults, the derived TAG_W, the line-record typedef (valid, tag, 4 words) and the address field-extraction helpers.
REQ-026 A sub-module main_mem SHALL implement the main-memory model with a combinational block read port (block address in, 4 words out) and a single-word read port for MISS_FORWARD_EN.

Verification
REQ-027 Reset: rst=0 for 2 cycles with address=0x0000 -> hit=0 and outData=0x00000000 throughout.
REQ-028 Cold miss then hit: after reset, hold address=0x0001 -> first cycle hit=0 and outData=0 (0x00010001 with MISS_FORWARD_EN); after one edge hit=1 and outData=0x00010001.
REQ-029 Same-block hit: after REQ-028, address=0x0003 -> hit=1 immediately and outData=0x00030003.
REQ-030 Conflict eviction: address=0x0800 (index 0, tag 0x08) -> miss, then hit with outData=0x08000800; return to 0x0001 -> miss again.
REQ-031 Independent index: address=0x1234 -> miss, next cycle hit with outData=0x12341234, and line 0 is unaffected.
REQ-032 Async reset mid-operation: assert rst between edges while hitting -> hit falls to 0 immediately; after release, the previously cached address misses once and then hits.
